// File: rtl/axi4_burst_mem_slave.sv
// AXI4 burst memory slave: FIXED/INCR/WRAP bursts, byte strobes, ID echo,
// per-beat address decode with DECERR, and a configurable read latency.
// The read and write channels have separate state machines and share only the array.
module axi4_burst_mem_slave #(
  parameter int                DATA_W    = 64,
  parameter int                ADDR_W    = 32,
  parameter int                ID_W      = 4,
  parameter int                DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                READ_LAT  = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  output logic                rvalid,
  input  logic                rready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast
);
  localparam int              BYTES     = DATA_W / 8;
  localparam int              BSZ       = $clog2(BYTES);
  localparam int              IDX_W     = $clog2(DEPTH);
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH * BYTES);
  localparam logic [1:0]      OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [1:0]      B_FIXED = 2'b00, B_INCR = 2'b01, B_WRAP = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

  // Address of the beat after 'a'; WRAP stays inside a (len+1)<<size window.
  function automatic logic [ADDR_W-1:0] f_next(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_W-1:0] step, mask;
    step = ADDR_W'(1) << size;
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    case (burst)
      B_FIXED: f_next = a;
      B_WRAP:  f_next = (a & ~mask) | ((a + step) & mask);
      default: f_next = a + step;
    endcase
  endfunction

  function automatic logic f_oob(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off   = a - BASE_ADDR;
    f_oob = ({1'b0, off} >= MEM_BYTES);
  endfunction

  // Word index, wrapped modulo DEPTH by truncation.
  function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off   = a - BASE_ADDR;
    f_idx = IDX_W'(off >> BSZ);
  endfunction

  // Bursts that are executed as INCR and flagged SLVERR.
  function automatic logic f_illegal(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    f_illegal = (burst == 2'b11) || (size > 3'(BSZ)) ||
                ((burst == B_WRAP) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  // Response codes are ordered so the numerically larger one is the worse one.
  function automatic logic [1:0] f_worst(input logic [1:0] a, input logic [1:0] b);
    f_worst = (a > b) ? a : b;
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];

  wstate_t           r_wstate;
  logic              r_awready, r_wready, r_bvalid;
  logic [1:0]        r_bresp, r_werr, r_wburst;
  logic [ID_W-1:0]   r_bid, r_wid;
  logic [ADDR_W-1:0] r_waddr;
  logic [7:0]        r_wlen, r_wcnt;
  logic [2:0]        r_wsize;
  logic              w_woob, w_wbeat, w_wlast_exp;
  logic [1:0]        w_wbeat_err;
  logic [IDX_W-1:0]  w_widx;

  assign w_woob      = f_oob(r_waddr);
  assign w_widx      = f_idx(r_waddr);
  assign w_wbeat     = r_wready && wvalid;
  assign w_wlast_exp = (r_wcnt == r_wlen);
  assign w_wbeat_err = f_worst(r_werr, f_worst(w_woob ? DECERR : OKAY,
                                               (wlast != w_wlast_exp) ? SLVERR : OKAY));

  // Write FSM: accept AW, count W beats up to len, then hold B until accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
      r_bid     <= '0;
      r_wid     <= '0;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wsize   <= '0;
      r_wburst  <= B_INCR;
      r_wcnt    <= '0;
      r_werr    <= OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: if (awvalid) begin
          r_wid     <= awid;
          r_waddr   <= awaddr;
          r_wlen    <= awlen;
          r_wsize   <= awsize;
          r_wburst  <= f_illegal(awlen, awsize, awburst) ? B_INCR : awburst;
          r_werr    <= f_illegal(awlen, awsize, awburst) ? SLVERR : OKAY;
          r_wcnt    <= '0;
          r_awready <= 1'b0;
          r_wready  <= 1'b1;
          r_wstate  <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          r_waddr <= f_next(r_waddr, r_wlen, r_wsize, r_wburst);
          r_wcnt  <= r_wcnt + 8'd1;
          r_werr  <= w_wbeat_err;
          if (w_wlast_exp) begin
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_bresp  <= w_wbeat_err;
            r_bid    <= r_wid;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: if (bready) begin
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wstate  <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Byte-enabled array write; out-of-range beats are dropped.
  always_ff @(posedge clock) begin
    if (w_wbeat && !w_woob) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wstrb[i]) r_mem[w_widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  rstate_t           r_rstate;
  logic              r_arready, r_rvalid, r_rlast, r_rill;
  logic [1:0]        r_rresp, r_rburst;
  logic [ID_W-1:0]   r_rid;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_raddr;
  logic [7:0]        r_rlen, r_rcnt;
  logic [2:0]        r_rsize;
  logic [3:0]        r_lat;
  logic              w_ridle, w_rld_ill, w_rld_oob, w_rload, w_rfinal;
  logic [ADDR_W-1:0] w_rld_addr;
  logic [7:0]        w_rld_len, w_rld_idx;
  logic [2:0]        w_rld_size;
  logic [1:0]        w_rld_burst;

  // In IDLE the first beat is loaded straight from AR (zero-latency case).
  assign w_ridle     = (r_rstate == R_IDLE);
  assign w_rld_addr  = w_ridle ? araddr : r_raddr;
  assign w_rld_len   = w_ridle ? arlen : r_rlen;
  assign w_rld_size  = w_ridle ? arsize : r_rsize;
  assign w_rld_ill   = w_ridle ? f_illegal(arlen, arsize, arburst) : r_rill;
  assign w_rld_burst = w_rld_ill ? B_INCR : (w_ridle ? arburst : r_rburst);
  assign w_rld_oob   = f_oob(w_rld_addr);
  assign w_rld_idx   = (r_rstate == R_DATA) ? (r_rcnt + 8'd1) : 8'd0;
  assign w_rfinal    = (r_rstate == R_DATA) && rready && r_rlast;
  assign w_rload     = (w_ridle && arvalid && (READ_LAT == 0)) ||
                       ((r_rstate == R_WAIT) && (r_lat == 4'd0)) ||
                       ((r_rstate == R_DATA) && rready && !r_rlast);

  // Read FSM: accept AR, wait READ_LAT cycles, stream beats until the rlast handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rid     <= '0;
      r_rlen    <= '0;
      r_rsize   <= '0;
      r_rburst  <= B_INCR;
      r_rill    <= 1'b0;
      r_lat     <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (arvalid) begin
          r_arready <= 1'b0;
          r_rid     <= arid;
          r_rlen    <= arlen;
          r_rsize   <= arsize;
          r_rburst  <= w_rld_burst;
          r_rill    <= w_rld_ill;
          if (READ_LAT == 0) begin
            r_rvalid <= 1'b1;
            r_rstate <= R_DATA;
          end else begin
            r_lat    <= 4'(READ_LAT - 1);
            r_rstate <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_lat == 4'd0) begin
            r_rvalid <= 1'b1;
            r_rstate <= R_DATA;
          end else begin
            r_lat <= r_lat - 4'd1;
          end
        end
        R_DATA: if (w_rfinal) begin
          r_rvalid  <= 1'b0;
          r_arready <= 1'b1;
          r_rstate  <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Read beat registers: reloaded only on handshake so they stay stable while stalled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rdata <= '0;
      r_rresp <= OKAY;
      r_rlast <= 1'b0;
      r_rcnt  <= '0;
      r_raddr <= '0;
    end else if (w_rload) begin
      r_rdata <= w_rld_oob ? '0 : r_mem[f_idx(w_rld_addr)];
      r_rresp <= w_rld_oob ? DECERR : (w_rld_ill ? SLVERR : OKAY);
      r_rlast <= (w_rld_idx == w_rld_len);
      r_rcnt  <= w_rld_idx;
      r_raddr <= f_next(w_rld_addr, w_rld_len, w_rld_size, w_rld_burst);
    end else if (w_ridle && arvalid) begin
      r_raddr <= araddr;
    end else if (w_rfinal) begin
      r_rlast <= 1'b0;
    end
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign bid     = r_bid;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rlast   = r_rlast;
  assign rid     = r_rid;

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Directed bench for axi4_burst_mem_slave (default parameters, READ_LAT=1).
module tb_axi4_burst_mem_slave;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;
  logic [3:0]  awid = 0, arid = 0, bid, rid;
  logic [31:0] awaddr = 0, araddr = 0;
  logic [7:0]  awlen = 0, arlen = 0;
  logic [2:0]  awsize = 3, arsize = 3;
  logic [1:0]  awburst = 1, arburst = 1, bresp, rresp;
  logic [63:0] wdata = 0, rdata;
  logic [7:0]  wstrb = 0;

  int          total = 0;
  int          bad = 0;
  logic [63:0] wd [0:15];
  logic [7:0]  ws [0:15];
  logic [63:0] rd [0:15];
  logic [1:0]  rr [0:15];
  logic        rl [0:15];
  logic [3:0]  rido [0:15];
  int          rlat, rcount;
  logic [1:0]  wr_resp;
  logic [3:0]  wr_id;

  axi4_burst_mem_slave dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives AW, len+1 W beats from wd/ws (wlast on beat last_beat), then collects B.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int last_beat,
                          output logic [1:0] resp, output logic [3:0] bido);
    int n;
    awvalid = 1; awid = id; awaddr = addr; awlen = len; awsize = 3; awburst = burst;
    n = 0;
    while (!awready && n < 100) begin @(negedge clock); n++; end
    check("aw_accept", 64'(awready), 64'd1);
    @(negedge clock);
    awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == last_beat);
      n = 0;
      while (!wready && n < 100) begin @(negedge clock); n++; end
      check("w_accept", 64'(wready), 64'd1);
      @(negedge clock);
    end
    wvalid = 0; wlast = 0;
    bready = 1;
    n = 0;
    while (!bvalid && n < 100) begin @(negedge clock); n++; end
    check("b_valid", 64'(bvalid), 64'd1);
    resp = bresp; bido = bid;
    @(negedge clock);
    bready = 0;
  endtask

  // Issues AR and collects up to stop_after beats into rd/rr/rl/rido.
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input bit stall, input int stop_after);
    int n, beat, cyc;
    logic hold;
    logic [63:0] hd;
    arvalid = 1; arid = id; araddr = addr; arlen = len; arsize = 3; arburst = burst;
    n = 0;
    while (!arready && n < 100) begin @(negedge clock); n++; end
    check("ar_accept", 64'(arready), 64'd1);
    @(negedge clock);
    arvalid = 0;
    beat = 0; cyc = 1; hold = 0; rlat = -1; hd = '0;
    while (beat <= int'(len) && beat < stop_after && cyc < 500) begin
      rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (hold) check("r_hold", rdata, hd);
      hold = 0;
      if (rvalid) begin
        if (rlat < 0) rlat = cyc;
        if (rready) begin
          rd[beat] = rdata; rr[beat] = rresp; rl[beat] = rlast; rido[beat] = rid;
          beat++;
        end else begin
          hold = 1; hd = rdata;
        end
      end
      @(negedge clock);
      cyc++;
    end
    rready = 0;
    rcount = beat;
    if (stop_after > int'(len)) begin
      check("rd_beats", 64'(rcount), 64'(int'(len) + 1));
      check("rvalid_drop", 64'(rvalid), 64'd0);
      check("arready_back", 64'(arready), 64'd1);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check("rst_awready", 64'(awready), 64'd1);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_arready", 64'(arready), 64'd1);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rbus", {52'd0, rid, rresp, rlast, 1'b0, bresp, bid}, 64'd0);
    check("rst_rdata", rdata, 64'd0);
    reset = 1;
    @(negedge clock);

    // INCR write of words 0..3, then read back
    wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
    for (int i = 0; i < 16; i++) ws[i] = 8'hFF;
    do_write(4'd5, 32'h8000_0000, 8'd3, 2'd1, 3, wr_resp, wr_id);
    check("incr_bresp", 64'(wr_resp), 64'd0);
    check("incr_bid", 64'(wr_id), 64'd5);
    do_read(4'd9, 32'h8000_0000, 8'd3, 2'd1, 0, 99);
    check("incr_lat", 64'(rlat), 64'd2);
    for (int i = 0; i < 4; i++) begin
      check("incr_rdata", rd[i], 64'((i + 1) * 8'h11));
      check("incr_rlast", 64'(rl[i]), 64'(i == 3));
      check("incr_rresp", 64'(rr[i]), 64'd0);
      check("incr_rid", 64'(rido[i]), 64'd9);
    end

    // Words 4,5 for the illegal-WRAP case
    wd[0] = 64'h55; wd[1] = 64'h66;
    do_write(4'd1, 32'h8000_0020, 8'd1, 2'd1, 1, wr_resp, wr_id);
    check("w45_bresp", 64'(wr_resp), 64'd0);

    // Legal WRAP: words 3,0,1,2
    do_read(4'd2, 32'h8000_0018, 8'd3, 2'd2, 0, 99);
    check("wrap_d0", rd[0], 64'h44);
    check("wrap_d1", rd[1], 64'h11);
    check("wrap_d2", rd[2], 64'h22);
    check("wrap_d3", rd[3], 64'h33);
    check("wrap_resp", 64'(rr[0]), 64'd0);

    // Illegal WRAP len=2 runs as INCR with SLVERR
    do_read(4'd2, 32'h8000_0018, 8'd2, 2'd2, 0, 99);
    check("bwrap_d0", rd[0], 64'h44);
    check("bwrap_d1", rd[1], 64'h55);
    check("bwrap_d2", rd[2], 64'h66);
    check("bwrap_resp0", 64'(rr[0]), 64'd2);
    check("bwrap_resp2", 64'(rr[2]), 64'd2);
    check("bwrap_rlast", 64'(rl[2]), 64'd1);

    // Out-of-range write: beat 0 below base (dropped), beat 1 lands on word 0 with no strobes
    wd[0] = 64'hDEAD_BEEF_0000_0001; wd[1] = 64'hDEAD_BEEF_0000_0002;
    ws[0] = 8'hFF; ws[1] = 8'h00;
    do_write(4'd3, 32'h7FFF_FFF8, 8'd1, 2'd1, 1, wr_resp, wr_id);
    check("oob_bresp", 64'(wr_resp), 64'd3);
    ws[1] = 8'hFF;
    do_read(4'd0, 32'h8000_0000, 8'd0, 2'd1, 0, 99);
    check("oob_mem_kept", rd[0], 64'h11);
    do_read(4'd0, 32'h8000_8000, 8'd0, 2'd1, 0, 99);
    check("oob_rdata", rd[0], 64'd0);
    check("oob_rresp", 64'(rr[0]), 64'd3);

    // Stalled len=15 read concurrent with a len=15 write elsewhere
    for (int i = 0; i < 16; i++) wd[i] = 64'hA000 + 64'(i);
    do_write(4'd4, 32'h8000_0200, 8'd15, 2'd1, 15, wr_resp, wr_id);
    for (int i = 0; i < 16; i++) wd[i] = 64'hB000 + 64'(i);
    fork
      do_write(4'd6, 32'h8000_1000, 8'd15, 2'd1, 15, wr_resp, wr_id);
      do_read(4'd7, 32'h8000_0200, 8'd15, 2'd1, 1, 99);
    join
    check("conc_bresp", 64'(wr_resp), 64'd0);
    check("conc_bid", 64'(wr_id), 64'd6);
    for (int i = 0; i < 16; i++) check("stall_rdata", rd[i], 64'hA000 + 64'(i));
    do_read(4'd7, 32'h8000_1000, 8'd15, 2'd1, 0, 99);
    for (int i = 0; i < 16; i++) check("conc_wdata", rd[i], 64'hB000 + 64'(i));

    // Partial strobe over an all-ones word
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    do_write(4'd0, 32'h8000_0040, 8'd0, 2'd1, 0, wr_resp, wr_id);
    wd[0] = 64'd0; ws[0] = 8'h0F;
    do_write(4'd0, 32'h8000_0040, 8'd0, 2'd1, 0, wr_resp, wr_id);
    check("strb_bresp", 64'(wr_resp), 64'd0);
    do_read(4'd0, 32'h8000_0040, 8'd0, 2'd1, 0, 99);
    check("strb_rdata", rd[0], 64'hFFFF_FFFF_0000_0000);

    // Early wlast on beat 0 of a two-beat burst
    ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(4'd8, 32'h8000_0048, 8'd1, 2'd1, 0, wr_resp, wr_id);
    check("wlast_bresp", 64'(wr_resp), 64'd2);

    // Reset in the middle of a len=7 read after three beats
    do_read(4'd1, 32'h8000_0000, 8'd7, 2'd1, 0, 3);
    check("abort_d2", rd[2], 64'h33);
    reset = 0;
    #1;
    check("abort_rvalid", 64'(rvalid), 64'd0);
    check("abort_arready", 64'(arready), 64'd1);
    @(negedge clock);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    do_read(4'd3, 32'h8000_0008, 8'd0, 2'd1, 0, 99);
    check("post_rst_rdata", rd[0], 64'h22);
    check("post_rst_rid", 64'(rido[0]), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
